// File: rtl/array_frame_pkg.sv
// Shared types and constants for the 2x4x5 array frame transmitter.
// Element order: c fastest, then b, then a (a runs 2..3).
package array_frame_pkg;

    localparam int ELEM_W   = 2;
    localparam int N_A      = 2;
    localparam int A_BASE   = 2;
    localparam int N_B      = 4;
    localparam int N_C      = 5;
    localparam int HDR_W    = 5;

    localparam int N_ELEM   = N_A * N_B * N_C;
    localparam int LAST_IDX = N_ELEM - 1;
    localparam int DATA_W   = ELEM_W * N_ELEM;
    localparam int IDX_W    = 6;
    localparam int CNT_W    = 8;
    localparam int PAR_IDX  = N_ELEM;

    localparam int A_W = (N_A > 1) ? $clog2(N_A) : 1;
    localparam int B_W = (N_B > 1) ? $clog2(N_B) : 1;
    localparam int C_W = (N_C > 1) ? $clog2(N_C) : 1;

    // Header beat plus one beat per element, plus the parity beat when enabled.
    localparam int BEATS_NOPAR = N_ELEM + 1;
    localparam int BEATS_PAR   = N_ELEM + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    // a is the zero-based offset from A_BASE.
    function automatic logic [IDX_W-1:0] flat_idx(
        input logic [A_W-1:0] a,
        input logic [B_W-1:0] b,
        input logic [C_W-1:0] c
    );
        return IDX_W'((int'(a) * N_B + int'(b)) * N_C + int'(c));
    endfunction

endpackage

// File: rtl/array_frame_idx.sv
// Nested (a,b,c) element counter: c fastest, then b, then a.
// Produces the flat element index and a flag for the last element.
module array_frame_idx
    import array_frame_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    logic [A_W-1:0] r_a;
    logic [B_W-1:0] r_b;
    logic [C_W-1:0] r_c;

    logic w_c_wrap;
    logic w_b_wrap;
    logic w_a_wrap;

    assign w_c_wrap = (r_c == C_W'(N_C - 1));
    assign w_b_wrap = (r_b == B_W'(N_B - 1));
    assign w_a_wrap = (r_a == A_W'(N_A - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else if (i_advance) begin
            if (w_c_wrap) begin
                r_c <= '0;
                if (w_b_wrap) begin
                    r_b <= '0;
                    r_a <= w_a_wrap ? '0 : r_a + 1'b1;
                end else begin
                    r_b <= r_b + 1'b1;
                end
            end else begin
                r_c <= r_c + 1'b1;
            end
        end
    end

    assign o_idx  = flat_idx(r_a, r_b, r_c);
    assign o_last = w_c_wrap && w_b_wrap && w_a_wrap;

endmodule

// File: rtl/array_frame_tx.sv
// Frame serializer: captures header + 40 elements, streams header then elements.
// Define ARRAY_FRAME_TX_PARITY_EN to append a parity beat after element 39.
module array_frame_tx
    import array_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [HDR_W-1:0]  load_hdr,
    input  logic [DATA_W-1:0] load_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [HDR_W-1:0]  tx_data,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic [IDX_W-1:0]  tx_idx,
    output logic [CNT_W-1:0]  frame_cnt
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HDR_W-1:0]    r_hdr;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_frame_cnt;

    logic                w_load_fire;
    logic                w_tx_fire;
    logic                w_adv;
    logic                w_last;
    logic [IDX_W-1:0]    w_idx;
    logic [ELEM_W-1:0]   w_elem;

    assign w_load_fire = load_valid && load_ready;
    assign w_tx_fire   = tx_valid && tx_ready;
    assign w_adv       = (r_state == DATA) && tx_ready;

    array_frame_idx u_idx (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_load_fire),
        .i_advance (w_adv),
        .o_idx     (w_idx),
        .o_last    (w_last)
    );

    always_comb begin
        w_elem = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (w_idx == IDX_W'(i)) w_elem = r_data[i*ELEM_W +: ELEM_W];
        end
    end

`ifdef ARRAY_FRAME_TX_PARITY_EN
    // Captured registers are stable for the whole frame, so parity is ready
    // long before the parity beat.
    logic w_parity;
    assign w_parity = ^{r_hdr, r_data};
`endif

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        tx_valid    = 1'b0;
        tx_sof      = 1'b0;
        tx_eof      = 1'b0;
        tx_data     = '0;
        tx_idx      = '0;
        unique case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) w_state_nxt = HDR;
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_sof   = 1'b1;
                tx_data  = r_hdr;
                if (tx_ready) w_state_nxt = DATA;
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = {{(HDR_W-ELEM_W){1'b0}}, w_elem};
                tx_idx   = w_idx;
`ifdef ARRAY_FRAME_TX_PARITY_EN
                if (tx_ready && w_last) w_state_nxt = PAR;
`else
                tx_eof = w_last;
                if (tx_ready && w_last) w_state_nxt = IDLE;
`endif
            end
`ifdef ARRAY_FRAME_TX_PARITY_EN
            PAR: begin
                tx_valid = 1'b1;
                tx_eof   = 1'b1;
                tx_idx   = IDX_W'(PAR_IDX);
                tx_data  = {{(HDR_W-1){1'b0}}, w_parity};
                if (tx_ready) w_state_nxt = IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: the capture registers are reset too, so tx_data reads zero after
    // reset rather than exposing stale frame contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hdr       <= '0;
            r_data      <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_fire) begin
                r_hdr  <= load_hdr;
                r_data <= load_data;
            end
            if (w_tx_fire && tx_eof) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_array_frame_tx.sv
// Self-checking bench for array_frame_tx: directed steps with random frames
// and random tx_ready, checked against a beat-list reference model.
`timescale 1ns/1ps
module tb_array_frame_tx;
    import array_frame_pkg::*;

`ifdef ARRAY_FRAME_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              load_valid;
    logic              load_ready;
    logic [HDR_W-1:0]  load_hdr;
    logic [DATA_W-1:0] load_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [HDR_W-1:0]  tx_data;
    logic              tx_sof;
    logic              tx_eof;
    logic [IDX_W-1:0]  tx_idx;
    logic [CNT_W-1:0]  frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected beat list of the current frame.
    int         n_beats;
    logic [4:0] exp_data [42];
    logic       exp_sof  [42];
    logic       exp_eof  [42];
    logic [5:0] exp_idx  [42];
    int         model_cnt = 0;

    always #5 clk = ~clk;

    array_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_hdr   (load_hdr),
        .load_data  (load_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .tx_idx     (tx_idx),
        .frame_cnt  (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected(input logic [4:0] hdr, input logic [79:0] data);
        int i;
        int ones;
        exp_data[0] = hdr;
        exp_sof[0]  = 1'b1;
        exp_eof[0]  = 1'b0;
        exp_idx[0]  = 6'd0;
        for (int a = 2; a <= 3; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 5; c++) begin
                    i = ((a - 2) * 4 + b) * 5 + c;
                    exp_data[i+1] = {3'b000, data[i*2 +: 2]};
                    exp_sof[i+1]  = 1'b0;
                    exp_eof[i+1]  = (i == 39) && !PAR_ON;
                    exp_idx[i+1]  = 6'(i);
                end
        n_beats = 41;
        if (PAR_ON) begin
            ones         = $countones(data) + $countones(hdr);
            exp_data[41] = 5'(ones % 2);
            exp_sof[41]  = 1'b0;
            exp_eof[41]  = 1'b1;
            exp_idx[41]  = 6'd40;
            n_beats      = 42;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after capture.
    task automatic offer(input logic [4:0] hdr, input logic [79:0] data, input bit hold);
        load_valid = 1'b1;
        load_hdr   = hdr;
        load_data  = data;
        build_expected(hdr, data);
        check("load_ready_idle", 32'(load_ready), 32'd1);
        @(negedge clk);
        if (!hold) load_valid = 1'b0;
    endtask

    // mode 0: ready high, 1: ready 1,0,1,0..., 2: random ready.
    task automatic receive(input int mode, input int stop_beat, output int cycles);
        int         beat = 0;
        int         lim;
        bit         rdy;
        bit         prev_stall = 1'b0;
        logic [4:0] p_data = '0;
        logic       p_sof = 1'b0;
        logic       p_eof = 1'b0;
        logic [5:0] p_idx = '0;
        lim    = (stop_beat >= 0) ? stop_beat : n_beats;
        cycles = 0;
        while (beat < lim && cycles < 400) begin
            check("tx_valid_held", 32'(tx_valid), 32'd1);
            check("load_ready_busy", 32'(load_ready), 32'd0);
            if (prev_stall) begin
                check("stall_data", 32'(tx_data), 32'(p_data));
                check("stall_sof", 32'(tx_sof), 32'(p_sof));
                check("stall_eof", 32'(tx_eof), 32'(p_eof));
                check("stall_idx", 32'(tx_idx), 32'(p_idx));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                check("beat_data", 32'(tx_data), 32'(exp_data[beat]));
                check("beat_sof", 32'(tx_sof), 32'(exp_sof[beat]));
                check("beat_eof", 32'(tx_eof), 32'(exp_eof[beat]));
                check("beat_idx", 32'(tx_idx), 32'(exp_idx[beat]));
                beat++;
            end
            prev_stall = tx_valid && !rdy;
            p_data = tx_data;
            p_sof  = tx_sof;
            p_eof  = tx_eof;
            p_idx  = tx_idx;
            cycles++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("beat_count", 32'(beat), 32'(lim));
        if (stop_beat < 0) begin
            model_cnt = (model_cnt + 1) % 256;
            check("idle_valid", 32'(tx_valid), 32'd0);
            check("idle_load_ready", 32'(load_ready), 32'd1);
            check("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
        end
    endtask

    initial begin
        logic [79:0] pat;
        logic [79:0] d_a;
        logic [79:0] d_b;
        logic [4:0]  h_a;
        logic [4:0]  h_b;
        int          cyc;

        rst        = 1'b1;
        load_valid = 1'b0;
        load_hdr   = '0;
        load_data  = '0;
        tx_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_sof", 32'(tx_sof), 32'd0);
        check("rst_tx_eof", 32'(tx_eof), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_idx", 32'(tx_idx), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;

        // Pattern frame, ready high: one beat per cycle.
        for (int i = 0; i < 40; i++) pat[i*2 +: 2] = 2'(i % 4);
        offer(5'b00111, pat, 1'b0);
        receive(0, -1, cyc);
        check("cycles_ready_high", 32'(cyc), 32'(n_beats));

        // Same frame, ready toggling 1,0,1,0.
        offer(5'b00111, pat, 1'b0);
        receive(1, -1, cyc);
        check("cycles_ready_toggle", 32'(cyc), 32'(2 * n_beats - 1));

        // load_valid held for A then B; load bus switches to B during A.
        h_a = 5'($urandom());
        h_b = 5'($urandom());
        d_a = {16'($urandom()), $urandom(), $urandom()};
        d_b = {16'($urandom()), $urandom(), $urandom()};
        offer(h_a, d_a, 1'b1);
        load_hdr  = h_b;
        load_data = d_b;
        receive(2, -1, cyc);
        offer(h_b, d_b, 1'b0);
        receive(2, -1, cyc);

        // Random frames with random back-pressure.
        repeat (4) begin
            offer(5'($urandom()), {16'($urandom()), $urandom(), $urandom()}, 1'b0);
            receive(2, -1, cyc);
        end

        // Reset while element 17 is on the link.
        offer(5'($urandom()), {16'($urandom()), $urandom(), $urandom()}, 1'b0);
        receive(0, 18, cyc);
        check("pre_rst_idx", 32'(tx_idx), 32'd17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_tx_eof", 32'(tx_eof), 32'd0);
        check("midrst_load_ready", 32'(load_ready), 32'd1);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        offer(5'($urandom()), {16'($urandom()), $urandom(), $urandom()}, 1'b0);
        receive(0, -1, cyc);

        // 256 back-to-back frames from reset: frame_cnt wraps to zero.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        for (int f = 0; f < 256; f++) begin
            offer(5'($urandom()), {16'($urandom()), $urandom(), $urandom()}, 1'b1);
            receive(0, -1, cyc);
        end
        load_valid = 1'b0;
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

        if (PAR_ON) begin
            offer(5'b00001, {40{2'b01}}, 1'b0);
            receive(0, -1, cyc);
            check("par_cycles", 32'(cyc), 32'd42);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/array_frame_tx.md
# array_frame_tx

Transmit-side serializer for the 2×4×5 array of 2-bit elements consumed by the generated array-port modules. Accepts one whole frame in parallel: a 5-bit header word plus 40 packed 2-bit elements. Streams the frame as a header beat followed by one element per beat over a valid/ready link. Sits between the stimulus source and any block whose input is that array shape, which reads the stream in the same element order.

## Interface
- ELEM_W, 2, element width in bits
- N_A, 2, outer dimension (index range 2..3)
- N_B, 4, middle dimension (0..3)
- N_C, 5, inner dimension (0..4)
- HDR_W, 5, header width; also tx_data width (must be ≥ ELEM_W)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  frame offered
- load_ready  out  1  block can accept a frame
- load_hdr  in  HDR_W  header word
- load_data  in  ELEM_W*N_A*N_B*N_C (80)  element i at bits [i*ELEM_W +: ELEM_W]
- tx_valid  out  1  beat valid
- tx_ready  in  1  sink accepts beat
- tx_data  out  HDR_W  header, or element zero-extended
- tx_sof  out  1  current beat is the header
- tx_eof  out  1  current beat is the last of the frame
- tx_idx  out  6  element index of the current beat (0 on header)
- frame_cnt  out  8  completed frames, wraps 255→0

## Operation
- FSM states: IDLE, HDR, DATA, plus PAR when the parity feature is compiled in.
- IDLE: load_ready=1. load_valid&&load_ready captures load_hdr and load_data into registers, then goes to HDR.
- HDR: tx_valid=1, tx_sof=1, tx_data=header. On acceptance, go to DATA with idx=0.
- DATA: tx_data={zeros, elem[idx]}. Flat index i=((a-2)*N_B+b)*N_C+c; c increments fastest, then b, then a.
  - Accepted beat with idx<39: idx+1.
  - Accepted beat with idx=39: go to IDLE, or to PAR when enabled.
- tx_eof is asserted on the final beat only (idx=39, or the PAR beat when enabled).
- frame_cnt increments by 1 when the eof beat is accepted. Modulo 256.
- Stream rules:
  - Once tx_valid rises it stays high, and tx_data, tx_sof, tx_eof and tx_idx stay stable until tx_ready is sampled high.
  - tx_valid never depends combinationally on tx_ready.
- The captured frame is immune to load_* changes during transmission.
- Frame length: 41 beats, or 42 with parity.

## Timing
- Reset values:
  - load_ready=1 (state IDLE).
  - tx_valid, tx_sof, tx_eof = 0.
  - tx_data, tx_idx, frame_cnt = 0.
  - Capture registers = 0.
- Load accepted at edge T: header beat is visible in the cycle after T.
- With tx_ready held high, one beat is transferred per cycle.
- After the eof beat is accepted there is one cycle in IDLE, so load_ready=1 for at least one cycle between frames. Minimum frame period is 42 cycles (43 with parity).
- Reset asserted mid-frame:
  - Frame is aborted at that edge with no eof.
  - All outputs return to reset values next cycle.
  - frame_cnt clears.
- tx_ready toggling has no effect except stalling. A beat is lost or duplicated never.

## Configuration
- ARRAY_FRAME_TX_PARITY_EN defined:
  - PAR state appends one beat after element 39.
  - tx_data = {zeros, p}, where p = XOR of all 80 element bits and all header bits.
  - tx_eof is on the PAR beat; tx_idx=40 on that beat.
- Undefined: no PAR state, and tx_eof is on element 39.
- Parity is computed from the captured registers during HDR/DATA. It adds no latency to the PAR beat.

## Structure
- Package array_frame_pkg holds:
  - State enum (IDLE, HDR, DATA, PAR).
  - ELEM_W, N_A, N_B, N_C and HDR_W defaults.
  - N_ELEM = N_A*N_B*N_C, and LAST_IDX = N_ELEM-1.
  - Beat-count constants for both configurations.
- One sub-module, array_frame_idx: a nested (a,b,c) counter with clear/advance inputs, producing flat idx and a last flag. The top level instantiates it once.

## Test plan
- Reset, then load hdr=5'b00111 and data element i = i%4 with tx_ready=1:
  - Beats are 7, then 0,1,2,3,0,… ending at idx 39 = 3.
  - sof on beat 0, eof on beat 40, frame_cnt=1.
- Same frame with tx_ready toggling 1,0,1,0:
  - Identical beat sequence, 81 cycles of transmission.
  - tx_data stable whenever valid&&!ready.
- load_valid held high for two frames A and B:
  - B is captured exactly one cycle after A's eof.
  - load_ready is low during A.
  - Changing load_data mid-A does not alter A's beats.
- rst asserted while sending idx 17:
  - Next cycle tx_valid=0, load_ready=1, frame_cnt=0.
  - The next load restarts from the header.
- 256 frames back-to-back: frame_cnt wraps to 0 after the 256th eof.
- Parity on, all elements 2'b01 and hdr=5'b00001:
  - p = 40 ones XOR 1 = 1.
  - 42nd beat tx_data=1, eof=1, tx_idx=40.
